// File: rtl/pio_sched_pkg.sv
// Shared sizes and types for the PIO instruction-fetch scheduler.
package pio_sched_pkg;
   localparam int NUM_FSM = 4;
   localparam int ADDR_W  = 5;
   localparam int INSTR_W = 16;
   localparam int DIV_W   = 16;

   typedef logic [$clog2(NUM_FSM)-1:0] fsm_id_t;
   typedef logic [ADDR_W-1:0]          instr_addr_t;
   typedef logic [INSTR_W-1:0]         instr_t;
   typedef logic [DIV_W-1:0]           clkdiv_t;
   typedef logic [NUM_FSM-1:0]         fsm_mask_t;

   // FSM index k places after base, wrapping around NUM_FSM.
   function automatic fsm_id_t rr_next(fsm_id_t base, int k);
      return fsm_id_t'((int'(base) + k) % NUM_FSM);
   endfunction
endpackage

// File: rtl/pio_fetch_scheduler_if.sv
// Per-FSM control inputs, regfile port and fetch results of the scheduler.
interface pio_fetch_scheduler_if;
   import pio_sched_pkg::*;

   fsm_mask_t               fsm_en;
   fsm_mask_t               fsm_restart;
   fsm_mask_t               fsm_stall;
   instr_addr_t [NUM_FSM-1:0] fsm_pc;
   clkdiv_t [NUM_FSM-1:0]     clkdiv;
   instr_addr_t             rf_read_addr;
   instr_t                  rf_instr;
   instr_t                  instr_out;
   fsm_mask_t               instr_valid;
   fsm_mask_t               overrun;

   modport master (
      output fsm_en, fsm_restart, fsm_stall, fsm_pc, clkdiv, rf_instr,
      input  rf_read_addr, instr_out, instr_valid, overrun
   );

   modport slave (
      input  fsm_en, fsm_restart, fsm_stall, fsm_pc, clkdiv, rf_instr,
      output rf_read_addr, instr_out, instr_valid, overrun
   );
endinterface

// File: rtl/pio_clkdiv.sv
// Step-tick divider for one FSM: counts 0..N-1 and ticks on N-1; div=0 means N=2^DIV_W.
module pio_clkdiv
   import pio_sched_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    en,
   input  logic    restart,
   input  clkdiv_t div,
   output logic    tick
);
   clkdiv_t cnt_r;
   clkdiv_t last_s;

   // div-1 wraps to all-ones for div=0, which yields the 2^DIV_W period for free
   always_comb begin
      last_s = div - clkdiv_t'(1);
      tick   = en & (cnt_r == last_s);
   end

   // Counter register: held at zero while disabled or restarted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r <= '0;
      end else if (restart || !en || tick) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + clkdiv_t'(1);
      end
   end
endmodule

// File: rtl/pio_fetch_scheduler.sv
// Round-robin sharing of the instruction regfile read port among NUM_FSM state machines.
// Optional sticky overrun flags are built when PIO_SCHED_OVERRUN_EN is defined.
module pio_fetch_scheduler
   import pio_sched_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   pio_fetch_scheduler_if.slave  bus
);
   fsm_mask_t   tick_s;
   fsm_mask_t   eligible_s;
   fsm_mask_t   grant_s;
   fsm_mask_t   pending_r;
   fsm_mask_t   instr_valid_r;
   fsm_id_t     rr_r;
   fsm_id_t     grant_id_s;
   fsm_id_t     idx_s;
   logic        grant_any_s;
   logic        hit_s;
   instr_t      instr_out_r;
   instr_addr_t addr_s;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_FSM; gi++) begin : g_div
         pio_clkdiv u_div (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.fsm_en[gi]),
            .restart (bus.fsm_restart[gi]),
            .div     (bus.clkdiv[gi]),
            .tick    (tick_s[gi])
         );
      end
   endgenerate

   // Arbiter: first eligible FSM after rr wins; a restarting FSM is never granted
   always_comb begin
      eligible_s  = pending_r & ~bus.fsm_stall & bus.fsm_en & ~bus.fsm_restart;
      grant_id_s  = rr_r;
      grant_any_s = 1'b0;
      idx_s       = rr_r;
      hit_s       = 1'b0;
      for (int k = 1; k <= NUM_FSM; k++) begin
         idx_s       = rr_next(rr_r, k);
         hit_s       = ~grant_any_s & eligible_s[idx_s];
         grant_id_s  = hit_s ? idx_s : grant_id_s;
         grant_any_s = grant_any_s | hit_s;
      end
      grant_s             = '0;
      grant_s[grant_id_s] = grant_any_s;
      addr_s = grant_any_s ? bus.fsm_pc[grant_id_s] : bus.fsm_pc[rr_r];
   end

   // Pending requests: restart/disable clear, a fresh tick outranks the grant clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_r <= '0;
      end else begin
         for (int i = 0; i < NUM_FSM; i++) begin
            if (bus.fsm_restart[i] || !bus.fsm_en[i]) begin
               pending_r[i] <= 1'b0;
            end else if (tick_s[i]) begin
               pending_r[i] <= 1'b1;
            end else if (grant_s[i]) begin
               pending_r[i] <= 1'b0;
            end else begin
               pending_r[i] <= pending_r[i];
            end
         end
      end
   end

   // Fetch result register and round-robin pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_out_r   <= '0;
         instr_valid_r <= '0;
         rr_r          <= '0;
      end else begin
         instr_valid_r <= grant_s;
         if (grant_any_s) begin
            instr_out_r <= bus.rf_instr;
            rr_r        <= grant_id_s;
         end else begin
            instr_out_r <= instr_out_r;
            rr_r        <= rr_r;
         end
      end
   end

`ifdef PIO_SCHED_OVERRUN_EN
   fsm_mask_t overrun_r;

   // Sticky overrun: a tick found the previous request still waiting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overrun_r <= '0;
      end else begin
         for (int i = 0; i < NUM_FSM; i++) begin
            if (bus.fsm_restart[i]) begin
               overrun_r[i] <= 1'b0;
            end else if (tick_s[i] && pending_r[i] && !grant_s[i]) begin
               overrun_r[i] <= 1'b1;
            end else begin
               overrun_r[i] <= overrun_r[i];
            end
         end
      end
   end

   assign bus.overrun = overrun_r;
`else
   assign bus.overrun = '0;
`endif

   assign bus.rf_read_addr = rst ? addr_s : '0;
   assign bus.instr_out    = instr_out_r;
   assign bus.instr_valid  = instr_valid_r;
endmodule
